// File: rtl/fmul_share_arbiter.sv
// rtl/fmul_share_arbiter.sv - round-robin sharing of one pipelined float multiplier between two requesters
module fmul_share_arbiter #(
  parameter int LAT = 3
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [1:0]  req0_rm,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [1:0]  req1_rm,
  output logic        req1_ready,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_s,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic [1:0]  mul_rm,
  output logic        mul_e,
  input  logic [31:0] mul_s,
  output logic        busy
);

  // Owner tags travel alongside the multiplier stages; index LAT-1 lines up with mul_s.
  logic [LAT-1:0] tag_v;
  logic [LAT-1:0] tag_id;
  logic           rr;

  logic head_v;
  logic head_id;
  logic head_rdy;
  logic gnt_any;
  logic gnt_id;

  assign head_v  = tag_v[LAT-1];
  assign head_id = tag_id[LAT-1];
  assign rsp_s   = mul_s;

  always_comb begin
    head_rdy   = head_id ? rsp1_ready : rsp0_ready;
    mul_e      = 1'b1;
    gnt_any    = 1'b0;
    gnt_id     = 1'b0;
    mul_a      = 32'd0;
    mul_b      = 32'd0;
    mul_rm     = 2'd0;
    // The whole pipeline freezes only when a real result sits at the head unclaimed.
    if (clrn && head_v && !head_rdy) mul_e = 1'b0;
    if (clrn && mul_e) begin
      if (req0_valid && req1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = rr;
      end else if (req0_valid) begin
        gnt_any = 1'b1;
      end else if (req1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b1;
      end
    end
    if (gnt_any) begin
      mul_a  = gnt_id ? req1_a  : req0_a;
      mul_b  = gnt_id ? req1_b  : req0_b;
      mul_rm = gnt_id ? req1_rm : req0_rm;
    end
    req0_ready = gnt_any && !gnt_id;
    req1_ready = gnt_any && gnt_id;
    rsp0_valid = clrn && head_v && !head_id;
    rsp1_valid = clrn && head_v && head_id;
    busy       = clrn && (|tag_v);
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      tag_v  <= '0;
      tag_id <= '0;
      rr     <= 1'b0;
    end else if (mul_e) begin
      for (int i = LAT - 1; i > 0; i--) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      tag_v[0]  <= gnt_any;
      tag_id[0] <= gnt_id;
      if (gnt_any) rr <= ~gnt_id;
    end
  end

endmodule

// File: tb/tb_fmul_share_arbiter.sv
// tb/tb_fmul_share_arbiter.sv - scoreboard bench for fmul_share_arbiter with a behavioural multiplier
module tb_fmul_share_arbiter;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        clrn;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_rm, req1_rm;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_s, mul_a, mul_b, mul_s;
  logic [1:0]  mul_rm;
  logic        mul_e, busy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expq0[$];
  logic [31:0] expq1[$];
  int          slots[$];
  int          favour = 0;
  logic [31:0] mstage[LAT];

  fmul_share_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .clrn(clrn),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_rm(req0_rm), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_rm(req1_rm), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_s(rsp_s), .mul_a(mul_a), .mul_b(mul_b), .mul_rm(mul_rm), .mul_e(mul_e), .mul_s(mul_s), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Operands carry short mantissas, so products are exact and rounding mode is irrelevant.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [31:0] rnd_f();
    logic [7:0] e;
    logic [7:0] m;
    e = 8'($urandom_range(120, 134));
    m = 8'($urandom_range(0, 255));
    return {1'($urandom_range(0, 1)), e, m, 15'd0};
  endfunction

  always @(posedge clk) begin
    if (!clrn) begin
      for (int i = 0; i < LAT; i++) mstage[i] <= 32'd0;
    end else if (mul_e) begin
      for (int i = LAT - 1; i > 0; i--) mstage[i] <= mstage[i-1];
      mstage[0] <= fmul(mul_a, mul_b);
    end
  end
  assign mul_s = mstage[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, want, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: slots holds the owner of each in-flight op (-1 = bubble), newest first.
  always @(negedge clk) begin : model
    int          head;
    int          g;
    logic        exp_e;
    logic        any;
    logic [31:0] ea, eb;
    logic [1:0]  erm;
    if (!clrn) begin
      chk("rst_flags", {26'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, mul_e, busy}, 32'h2);
      chk("rst_operands", mul_a | mul_b | {30'd0, mul_rm}, 32'd0);
      slots.delete();
      repeat (LAT) slots.push_back(-1);
      favour = 0;
      expq0.delete();
      expq1.delete();
    end else begin
      head  = slots[LAT-1];
      exp_e = !(head >= 0 && !(head == 0 ? rsp0_ready : rsp1_ready));
      g = -1;
      if (exp_e) begin
        if (req0_valid && req1_valid) g = favour;
        else if (req0_valid)          g = 0;
        else if (req1_valid)          g = 1;
      end
      any = 1'b0;
      foreach (slots[i]) if (slots[i] >= 0) any = 1'b1;
      chkb("mul_e", mul_e, exp_e);
      chkb("req0_ready", req0_ready, g == 0);
      chkb("req1_ready", req1_ready, g == 1);
      chkb("rsp0_valid", rsp0_valid, head == 0);
      chkb("rsp1_valid", rsp1_valid, head == 1);
      chkb("busy", busy, any);
      ea  = (g == 0) ? req0_a  : (g == 1) ? req1_a  : 32'd0;
      eb  = (g == 0) ? req0_b  : (g == 1) ? req1_b  : 32'd0;
      erm = (g == 0) ? req0_rm : (g == 1) ? req1_rm : 2'd0;
      chk("mul_a", mul_a, ea);
      chk("mul_b", mul_b, eb);
      chk("mul_rm", {30'd0, mul_rm}, {30'd0, erm});
      if (g == 0) expq0.push_back(fmul(req0_a, req0_b));
      if (g == 1) expq1.push_back(fmul(req1_a, req1_b));
      if (exp_e) begin
        void'(slots.pop_back());
        slots.push_front(g);
        if (g >= 0) favour = 1 - g;
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic        hold;
    logic [31:0] hold_s;
    if (!clrn) begin
      hold = 1'b0;
    end else begin
      if (hold) chk("stall_hold_rsp_s", rsp_s, hold_s);
      if (rsp0_valid && rsp0_ready) begin
        if (expq0.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp0_unexpected got=%h want=none at %0t", rsp_s, $time);
        end else chk("rsp0_data", rsp_s, expq0.pop_front());
      end
      if (rsp1_valid && rsp1_ready) begin
        if (expq1.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp1_unexpected got=%h want=none at %0t", rsp_s, $time);
        end else chk("rsp1_data", rsp_s, expq1.pop_front());
      end
      hold   = (rsp0_valid && !rsp0_ready) || (rsp1_valid && !rsp1_ready);
      hold_s = rsp_s;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    clrn = 1'b0;
    idle_reqs();
    step();
    clrn = 1'b1;
  endtask

  task automatic issue_wait(input int port, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] want, input string name);
    int          got;
    logic [31:0] s;
    logic        other;
    got = -1; s = 32'd0; other = 1'b0;
    if (port == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_rm = 2'd0;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_rm = 2'd0;
    end
    #1;
    chkb({name, "_accept"}, port == 0 ? req0_ready : req1_ready, 1'b1);
    for (int k = 1; k <= LAT + 2; k++) begin
      step();
      if (k == 1) idle_reqs();
      if (got < 0 && (port == 0 ? rsp0_valid : rsp1_valid)) begin
        got = k;
        s   = rsp_s;
      end
      if (port == 0 ? rsp1_valid : rsp0_valid) other = 1'b1;
    end
    chk({name, "_latency"}, got, LAT);
    chk({name, "_data"}, s, want);
    chkb({name, "_no_other_rsp"}, other, 1'b0);
  endtask

  initial begin
    slots.delete();
    repeat (LAT) slots.push_back(-1);
    clrn = 1'b0;
    req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_rm = 2'd0;
    req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_rm = 2'd0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (2) step();
    clrn = 1'b1;

    issue_wait(0, 32'h3fc00000, 32'h3fc00000, 32'h40100000, "t1");

    pulse_reset();
    req0_valid = 1'b1; req0_a = 32'h3f800000; req0_b = 32'h40000000; req0_rm = 2'd0;
    req1_valid = 1'b1; req1_a = 32'h40400000; req1_b = 32'h40400000; req1_rm = 2'd2;
    repeat (8) step();
    idle_reqs();
    repeat (LAT + 2) step();

    pulse_reset();
    rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h40000000; req1_b = 32'h40400000; req1_rm = 2'd1;
    repeat (LAT) step();
    req0_valid = 1'b1; req0_a = 32'h40800000; req0_b = 32'h40800000; req0_rm = 2'd3;
    repeat (2) step();
    req0_valid = 1'b0;
    repeat (2) step();
    rsp1_ready = 1'b1;
    req1_valid = 1'b0;
    repeat (LAT + 2) step();

    req0_valid = 1'b1; req0_a = 32'h3fc00000; req0_b = 32'h40000000;
    step();
    req0_valid = 1'b0;
    repeat (2) step();
    issue_wait(1, 32'h40000000, 32'h40800000, 32'h41000000, "t4");
    chkb("t4_busy_idle", busy, 1'b0);

    req0_valid = 1'b1; req0_a = 32'h40000000; req0_b = 32'h40000000;
    req1_valid = 1'b1; req1_a = 32'h40400000; req1_b = 32'h40000000;
    repeat (2) step();
    pulse_reset();
    chkb("t5_busy_after_reset", busy, 1'b0);
    repeat (LAT + 2) step();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chkb("t5_grant_port0", req0_ready, 1'b1);
    step();
    idle_reqs();
    repeat (LAT + 2) step();

    repeat (400) begin
      req0_valid = ($urandom_range(0, 9) < 6);
      req0_a = rnd_f(); req0_b = rnd_f(); req0_rm = 2'($urandom_range(0, 3));
      req1_valid = ($urandom_range(0, 9) < 6);
      req1_a = rnd_f(); req1_b = rnd_f(); req1_rm = 2'($urandom_range(0, 3));
      rsp0_ready = ($urandom_range(0, 9) < 7);
      rsp1_ready = ($urandom_range(0, 9) < 7);
      clrn = ($urandom_range(0, 99) != 0);
      step();
    end

    clrn = 1'b1;
    idle_reqs();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (LAT + 3) step();
    chk("drain_q0_empty", expq0.size(), 0);
    chk("drain_q1_empty", expq1.size(), 0);
    chkb("drain_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
